csa_resolver: RTL and testbench

//   Consumer end of the carry-save adder path: accepts one redundant (sum, carry) pair per transaction
//   and resolves it into a plain binary result by iterating s'=s^c, c'=(s&c)<<1 until c==0.

---
 rtl/csa_pkg.sv | 6 +
 rtl/csa_resolve_step.sv | 16 +
 rtl/csa_resolver.sv | 71 +++++++
 tb/tb_csa_resolver.sv | 127 ++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// csa_pkg: shared default width, word type and resolver state encoding
package csa_pkg;
  localparam int CSA_WIDTH = 8;
  typedef logic [CSA_WIDTH-1:0] csa_word_t;
  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} csa_res_state_e;
endpackage

// File: rtl/csa_resolve_step.sv
// csa_resolve_step: one carry-resolve iteration (s,c) -> (s^c, (s&c)<<1, carry-out)
module csa_resolve_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s_n,
  output logic [WIDTH-1:0] c_n,
  output logic             cout
);
  logic [WIDTH-1:0] g;
  assign g    = s & c;
  assign s_n  = s ^ c;
  assign c_n  = {g[WIDTH-2:0], 1'b0};
  assign cout = g[WIDTH-1];
endmodule

// File: rtl/csa_resolver.sv
// csa_resolver: multi-cycle sum/carry resolver; define CSA_RESOLVER_OVF_EN to add the sticky out_ovf carry-out flag
module csa_resolver
  import csa_pkg::*;
#(
  parameter  int WIDTH = CSA_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [CNT_W-1:0] out_cycles
`ifdef CSA_RESOLVER_OVF_EN
  ,
  output logic             out_ovf
`endif
);
  csa_res_state_e state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, c_q, c_d, step_s, step_c;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic step_cout;
  logic accept, stepping;
  csa_resolve_step #(.WIDTH(WIDTH)) u_step (
    .s(s_q), .c(c_q), .s_n(step_s), .c_n(step_c), .cout(step_cout)
  );
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign out_result = s_q;
  assign out_cycles = iter_q;
  assign accept     = in_ready && in_valid;
  assign stepping   = state_q == RESOLVE && c_q != '0;
  always_comb begin
    state_d = state_q;
    s_d     = accept ? in_sum : stepping ? step_s : s_q;
    c_d     = accept ? in_carry : stepping ? step_c : c_q;
    iter_d  = accept ? '0 : stepping ? iter_q + 1'b1 : iter_q;
    case (state_q)
      IDLE:    state_d = in_valid ? RESOLVE : IDLE;
      RESOLVE: state_d = c_q == '0 ? DONE : RESOLVE;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      iter_q  <= iter_d;
    end
  end
`ifdef CSA_RESOLVER_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d   = accept ? 1'b0 : ovf_q | (stepping & step_cout);
  assign out_ovf = ovf_q;
  always_ff @(posedge clk) ovf_q <= rst ? 1'b0 : ovf_d;
`else
  logic unused_cout;
  assign unused_cout = step_cout;
`endif
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed and random transactions checked against an arithmetic reference model
module tb_csa_resolver;
  import csa_pkg::*;
  localparam int W = 8;
  localparam int CW = $clog2(W + 1);
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [W-1:0] in_sum = '0, in_carry = '0, out_result;
  logic [CW-1:0] out_cycles;
`ifdef CSA_RESOLVER_OVF_EN
  logic out_ovf;
`endif
  int n_checks = 0, n_fails = 0;

  csa_resolver dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_cycles(out_cycles)
`ifdef CSA_RESOLVER_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result is plain modular addition; iteration count and carry-out
  // follow the resolve rule s'=s^c, c'=(s&c)<<1 applied to integers.
  function automatic void model(input csa_word_t a, input csa_word_t b,
                                output int res, output int k, output bit ovf);
    int s, c;
    s = a; c = b; k = 0; ovf = 0;
    while (c != 0) begin
      if (((s & c) >> (W - 1)) & 1) ovf = 1;
      {s, c} = {s ^ c, ((s & c) * 2) % (1 << W)};
      k++;
    end
    res = (int'(a) + int'(b)) % (1 << W);
  endfunction

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    int er, ek, e;
    bit eo;
    logic [W-1:0] r0;
    logic [CW-1:0] k0;
    model(a, b, er, ek, eo);
    @(negedge clk);
    chk("in_ready_before", in_ready, 1);
    in_valid = 1; in_sum = a; in_carry = b;
    @(negedge clk);
    in_valid = 0; in_sum = W'($urandom); in_carry = W'($urandom);
    e = 0;
    while (!out_valid && e < 40) begin
      @(negedge clk);
      e++;
    end
    chk("latency", e, ek + 1);
    chk("result", out_result, er);
    chk("cycles", out_cycles, ek);
`ifdef CSA_RESOLVER_OVF_EN
    chk("ovf", out_ovf, eo);
`endif
    r0 = out_result; k0 = out_cycles;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1; in_sum = W'($urandom); in_carry = W'($urandom);
      @(negedge clk);
      chk("stall_result", out_result, r0);
      chk("stall_cycles", out_cycles, k0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("back_idle_ready", in_ready, 1);
    chk("back_idle_valid", out_valid, 0);
  endtask

  initial begin
    int er, ek;
    bit eo;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_cycles", out_cycles, 0);
`ifdef CSA_RESOLVER_OVF_EN
    chk("rst_ovf", out_ovf, 0);
`endif
    model(8'h00, 8'h0E, er, ek, eo);
    chk("model_case1", ek, 1);
    model(8'hFF, 8'h01, er, ek, eo);
    chk("model_case3", {ek[15:0], 15'd0, eo}, {16'd8, 16'd1});
    run_txn(8'h00, 8'h0E, 0);
    run_txn(8'h0F, 8'h01, 0);
    run_txn(8'hFF, 8'h01, 0);
    run_txn(8'hA5, 8'h00, 0);
    run_txn(8'h3C, 8'h46, 5);
    @(negedge clk);
    in_valid = 1; in_sum = 8'hFF; in_carry = 8'h01;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid_resolve_busy", in_ready, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_cycles", out_cycles, 0);
    run_txn(8'h0F, 8'h01, 0);
    for (int t = 0; t < 40; t++)
      run_txn(W'($urandom), (t % 4 == 0) ? W'(1 << $urandom_range(W - 1)) : W'($urandom),
              int'($urandom_range(2)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
